seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scan scheduler with frame-coherent source capture and auto paging.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits of the current page.
module seg7_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned PAGE_FRAMES  = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        src_sel,
  input  logic        page_hold,
  output logic [6:0]  out0,
  output logic [3:0]  enable,
  output logic        dp
);

  localparam int unsigned PH_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned FR_W   = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

  localparam logic [PH_W-1:0] DIGIT_LAST = PH_W'(DIGIT_CYCLES - 1);
  localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_CYCLES - 1);
  localparam logic [FR_W-1:0] FRAME_LAST = FR_W'(PAGE_FRAMES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]      state;
  logic [1:0]      idx;
  logic [PH_W-1:0] ph_cnt;
  logic [FR_W-1:0] fr_cnt;
  logic            page;
  logic [31:0]     shadow;

  logic [15:0] half;
  logic [3:0]  nibble;
  logic        lz_blank;
  logic [6:0]  drv_seg;
  logic [3:0]  drv_en;
  logic        drv_dp;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Drive values are computed from the digit about to be (or being) shown.
  always_comb begin
    half     = page ? shadow[31:16] : shadow[15:0];
    nibble   = half[{idx, 2'b00} +: 4];
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd1:    lz_blank = (half[15:4] == '0);
      2'd2:    lz_blank = (half[15:8] == '0);
      2'd3:    lz_blank = (half[15:12] == '0);
      default: lz_blank = 1'b0;
    endcase
`endif
    drv_seg = lz_blank ? 7'h7F : hex7(nibble);
    drv_en  = ~(4'b0001 << idx);
    drv_dp  = ~((idx == 2'd3) && page);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_BLANK;
      idx    <= '0;
      ph_cnt <= '0;
      fr_cnt <= '0;
      page   <= 1'b0;
      shadow <= '0;
      enable <= '1;
      out0   <= '1;
      dp     <= 1'b1;
    end else begin
      case (state)
        ST_BLANK: begin
          if (ph_cnt == BLANK_LAST) begin
            state  <= ST_DRIVE;
            ph_cnt <= '0;
            enable <= drv_en;
            out0   <= drv_seg;
            dp     <= drv_dp;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
            enable <= '1;
            out0   <= '1;
            dp     <= 1'b1;
          end
        end
        default: begin
          if (ph_cnt == DIGIT_LAST) begin
            state  <= ST_BLANK;
            ph_cnt <= '0;
            idx    <= (idx == 2'd3) ? 2'd0 : idx + 2'd1;
            enable <= '1;
            out0   <= '1;
            dp     <= 1'b1;
            if (idx == 2'd3) begin
              shadow <= src_sel ? data_b : data_a;
              if (!page_hold) begin
                if (fr_cnt == FRAME_LAST) begin
                  fr_cnt <= '0;
                  page   <= ~page;
                end else begin
                  fr_cnt <= fr_cnt + 1'b1;
                end
              end
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
            enable <= drv_en;
            out0   <= drv_seg;
            dp     <= drv_dp;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Frame-table bench for seg7_scan_ctrl: each record gives mid-frame inputs and the expected digits of that frame.
module tb_seg7_scan_ctrl;

  localparam int unsigned DC = 4;

  localparam logic [6:0] S_0 = 7'h40, S_1 = 7'h79, S_2 = 7'h24, S_3 = 7'h30, S_4 = 7'h19;
  localparam logic [6:0] S_8 = 7'h00, S_A = 7'h08, S_B = 7'h03, S_C = 7'h46, S_D = 7'h21, S_F = 7'h0E;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif

  typedef struct packed {
    logic [31:0]     da;
    logic [31:0]     db;
    logic            sel;
    logic            hold;
    logic [3:0][6:0] seg;
    logic            pg;
  } frame_t;

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] data_a, data_b;
  logic        src_sel, page_hold;
  logic [6:0]  out0;
  logic [3:0]  enable;
  logic        dp;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        mon_on = 1'b0;
  exp_t        q[$];
  frame_t      tab[25];

  seg7_scan_ctrl #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1), .PAGE_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .data_a(data_a), .data_b(data_b),
    .src_sel(src_sel), .page_hold(page_hold),
    .out0(out0), .enable(enable), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (!$onehot0(~enable)) begin
        bad++;
        $display("FAIL anode_onehot: enable=%h required at most one low", enable);
      end
    end
  end

  function automatic frame_t mk(input logic [31:0] da, input logic [31:0] db, input logic sel,
                                input logic hold, input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3, input logic pg);
    frame_t f;
    f.da = da; f.db = db; f.sel = sel; f.hold = hold;
    f.seg = {s3, s2, s1, s0}; f.pg = pg;
    return f;
  endfunction

  task automatic push_frame(input logic [3:0][6:0] seg, input logic pg);
    logic [3:0] en_tab [4];
    exp_t e;
    en_tab[0] = 4'hE; en_tab[1] = 4'hD; en_tab[2] = 4'hB; en_tab[3] = 4'h7;
    for (int k = 0; k < 4; k++) begin
      e.en = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      q.push_back(e);
      for (int c = 0; c < DC; c++) begin
        e.en = en_tab[k]; e.seg = seg[k]; e.dp = !(pg && (k == 3));
        q.push_back(e);
      end
    end
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      if (enable !== e.en || out0 !== e.seg || dp !== e.dp) begin
        bad++;
        $display("FAIL %s: got enable=%h out0=%h dp=%b, required enable=%h out0=%h dp=%b",
                 tag, enable, out0, dp, e.en, e.seg, e.dp);
      end
    end
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      check_cycle(tag);
      @(negedge clk);
    end
  endtask

  initial begin
    tab[0]  = mk(32'h1234ABCD, 32'h0,      1'b0, 1'b0, S_0, Z,   Z,   Z,   1'b0);
    tab[1]  = mk(32'h1234ABCD, 32'h0,      1'b0, 1'b0, S_D, S_C, S_B, S_A, 1'b0);
    tab[2]  = mk(32'h1234ABCD, 32'h0,      1'b0, 1'b0, S_4, S_3, S_2, S_1, 1'b1);
    tab[3]  = mk(32'h1234ABCD, 32'h0,      1'b0, 1'b0, S_4, S_3, S_2, S_1, 1'b1);
    tab[4]  = mk(32'h1234ABCD, 32'h0000F00F, 1'b1, 1'b0, S_D, S_C, S_B, S_A, 1'b0);
    tab[5]  = mk(32'h1234ABCD, 32'h0000F00F, 1'b0, 1'b0, S_F, S_0, S_0, S_F, 1'b0);
    for (int f = 6; f < 18; f++)
      tab[f] = mk(32'h1234ABCD, 32'h0000F00F, 1'b0, 1'b1, S_4, S_3, S_2, S_1, 1'b1);
    tab[18] = mk(32'h1234ABCD, 32'h0000F00F, 1'b0, 1'b0, S_4, S_3, S_2, S_1, 1'b1);
    tab[19] = mk(32'h1234ABCD, 32'h0000F00F, 1'b0, 1'b0, S_4, S_3, S_2, S_1, 1'b1);
    tab[20] = mk(32'h1234ABCD, 32'h0000F00F, 1'b0, 1'b0, S_D, S_C, S_B, S_A, 1'b0);
    tab[21] = mk(32'h0000000A, 32'h0000F00F, 1'b0, 1'b0, S_D, S_C, S_B, S_A, 1'b0);
    tab[22] = mk(32'h0000000A, 32'h0000F00F, 1'b0, 1'b0, S_0, Z,   Z,   Z,   1'b1);
    tab[23] = mk(32'h0000000A, 32'h0000F00F, 1'b0, 1'b0, S_0, Z,   Z,   Z,   1'b1);
    tab[24] = mk(32'h0000000A, 32'h0000F00F, 1'b0, 1'b0, S_A, Z,   Z,   Z,   1'b0);

    reset = 1'b1; data_a = '0; data_b = '0; src_sel = 1'b0; page_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;

    // Inputs change mid-frame; they may only show up from the following frame on.
    for (int f = 0; f < 25; f++) begin
      push_frame(tab[f].seg, tab[f].pg);
      for (int c = 0; c < 20; c++) begin
        if (c == 10) begin
          data_a = tab[f].da; data_b = tab[f].db;
          src_sel = tab[f].sel; page_hold = tab[f].hold;
        end
        check_cycle($sformatf("frame%0d_c%0d", f, c));
        @(negedge clk);
      end
    end

    // Reset while digit 2 is being driven.
    push_frame({Z, Z, Z, S_A}, 1'b0);
    run_cycles(12, "pre_reset");
    check_cycle("pre_reset_idx2");
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    push_frame({Z, Z, Z, S_0}, 1'b0);
    run_cycles(20, "post_reset_frame0");
    push_frame({Z, Z, Z, S_A}, 1'b0);
    run_cycles(20, "post_reset_frame1");

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
